// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the program-counter generator: data width, default
// reset vector and PC increment, the PC FSM state type, the redirect record
// produced by the branch/jump arbiter, and a word-alignment helper.
// ---------------------------------------------------------------------------
package pc_gen_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned     DEF_INST_BYTES   = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    // One cycle's arbitrated redirect request.
    typedef struct packed {
        logic            valid;     // branch or jump requested this cycle
        logic [XLEN-1:0] target;    // selected target, forced to a word boundary
        logic            misalign;  // selected target had [1:0] != 0
    } redirect_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Bundle between the PC generator and its neighbours (fetch, hazard unit,
// branch/jump resolution).
//   stall_i / conflict_i          fetch stall and hazard hold
//   branch_taken_i / _target_i    taken branch and its destination
//   jump_i / jump_target_i        jump and its destination
//   pc_o                          address presented to fetch
//   pc_if_o / pc_if_valid_o       PC of the instruction fetch currently holds
//   misalign_o                    pulse: last applied target was not word aligned
// Modport master is the PC generator; slave is the surrounding pipeline.
// ---------------------------------------------------------------------------
interface pc_gen_if;
    import pc_gen_pkg::*;

    logic            stall_i;
    logic            conflict_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_if_o;
    logic            pc_if_valid_o;
    logic            misalign_o;

    modport master (
        input  stall_i, conflict_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i,
        output pc_o, pc_if_o, pc_if_valid_o, misalign_o
    );

    modport slave (
        output stall_i, conflict_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i,
        input  pc_o, pc_if_o, pc_if_valid_o, misalign_o
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Purely combinational branch/jump arbiter. The branch is the older
// instruction, so it beats a jump resolved in the same cycle. The selected
// target is forced to a word boundary and its low bits are reported.
//   branch_taken_i, branch_target_i   branch request and destination
//   jump_i, jump_target_i             jump request and destination
//   redir_o                           arbitrated redirect record
// ---------------------------------------------------------------------------
module pc_redirect_arb
    import pc_gen_pkg::*;
(
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output redirect_t       redir_o
);

    logic [XLEN-1:0] sel_target;

    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_target = jump_target_i;
        if (branch_taken_i) begin
            sel_target = branch_target_i;
        end
        redir_o.valid    = branch_taken_i | jump_i;
        redir_o.target   = align_word(sel_target);
        redir_o.misalign = |sel_target[1:0];
    end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program-counter generator feeding fetch. Advances pc by INST_BYTES, takes
// branch/jump redirects, holds on stall or hazard conflict, parks a redirect
// that arrives during a stall and applies it once the stall clears. Also
// tracks the PC of the instruction fetch is currently presenting so decode
// can pair each instruction with its address.
//   clk_i, rst_i   clock (rising edge) and synchronous active-high reset
//   bus            pc_gen_if.master: pipeline inputs and registered outputs
// ---------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned     INST_BYTES   = DEF_INST_BYTES
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pc_gen_if.master  bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] pc_if_q, pc_if_d;
    logic            pc_if_valid_q, pc_if_valid_d;
    logic            misalign_q, misalign_d;
    logic            flush;
    redirect_t       redir;

    pc_redirect_arb u_arb (
        .branch_taken_i  (bus.branch_taken_i),
        .branch_target_i (bus.branch_target_i),
        .jump_i          (bus.jump_i),
        .jump_target_i   (bus.jump_target_i),
        .redir_o         (redir)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pc_if_d       = pc_if_q;
        pc_if_valid_d = pc_if_valid_q;
        misalign_d    = 1'b0;
        flush         = 1'b0;

        unique case (state_q)
            // Single settling cycle at the reset vector; redirects ignored.
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (redir.valid) begin
                    flush      = 1'b1;
                    misalign_d = redir.misalign;
                    if (bus.stall_i) begin
                        pend_d  = redir.target;
                        state_d = HOLD;
                    end else begin
                        pc_d = redir.target;
                    end
                end else if (!(bus.stall_i || bus.conflict_i)) begin
                    // Natural wrap at 2^32 is the intended behaviour.
                    pc_d = pc_q + XLEN'(INST_BYTES);
                end
            end

            HOLD: begin
                // Younger redirects are on the flushed path; keep the first.
                if (!bus.stall_i) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                    // The instruction fetch delivers now belongs to the
                    // path the parked redirect squashed.
                    flush   = 1'b1;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        // Mirror of fetch's instruction register.
        if (flush) begin
            pc_if_valid_d = 1'b0;
        end else if (bus.conflict_i) begin
            pc_if_d       = pc_if_q;
            pc_if_valid_d = pc_if_valid_q;
        end else if (bus.stall_i) begin
            pc_if_valid_d = 1'b0;
        end else begin
            pc_if_d       = pc_q;
            pc_if_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_q        <= RESET_VECTOR;
            pc_if_q       <= '0;
            pc_if_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pc_if_q       <= pc_if_d;
            pc_if_valid_q <= pc_if_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_if_o       = pc_if_q;
    assign bus.pc_if_valid_o = pc_if_valid_q;
    assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Directed bench for pc_gen: a table of per-cycle input/expected-output
// records applied after reset, followed by a hand-written sequence that
// resets the block while a redirect is parked and checks that the boot
// sequence repeats from the reset vector.
// ---------------------------------------------------------------------------
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;

    pc_gen_if bus ();

    pc_gen #(
        .RESET_VECTOR (32'h0000_0000),
        .INST_BYTES   (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        conflict;
        logic        br;
        logic [31:0] br_tgt;
        logic        jmp;
        logic [31:0] jmp_tgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_if;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic c,
                                input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic [31:0] pc, input logic [31:0] pc_if,
                                input logic v, input logic m);
        vec_t r;
        r.stall = s; r.conflict = c; r.br = b; r.br_tgt = bt;
        r.jmp = j; r.jmp_tgt = jt; r.exp_pc = pc; r.exp_pc_if = pc_if;
        r.exp_valid = v; r.exp_mis = m;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic c, input logic b,
                         input logic [31:0] bt, input logic j,
                         input logic [31:0] jt);
        bus.stall_i         = s;
        bus.conflict_i      = c;
        bus.branch_taken_i  = b;
        bus.branch_target_i = bt;
        bus.jump_i          = j;
        bus.jump_target_i   = jt;
    endtask

    // Advance one edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc,
                             input logic [31:0] pc_if, input logic v,
                             input logic m);
        check({tag, " pc_o"},          bus.pc_o,                 pc);
        check({tag, " pc_if_o"},       bus.pc_if_o,              pc_if);
        check({tag, " pc_if_valid_o"}, {31'd0, bus.pc_if_valid_o}, {31'd0, v});
        check({tag, " misalign_o"},    {31'd0, bus.misalign_o},    {31'd0, m});
    endtask

    initial begin
        //            stall conf br  br_tgt        jmp jmp_tgt        pc             pc_if          v     m
        // Boot and sequential run
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0008, 32'h0000_0004, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_000C, 32'h0000_0008, 1'b1, 1'b0);
        // Branch beats jump in the same cycle
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h100,   1'b1, 32'h200,     32'h0000_0100, 32'h0000_0008, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0104, 32'h0000_0100, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b1, 1'b0);
        // Three stall cycles: jump parked, later branch ignored
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 32'h40,      32'h0000_0108, 32'h0000_0104, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h80,    1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0040, 32'h0000_0104, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0044, 32'h0000_0040, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0048, 32'h0000_0044, 1'b1, 1'b0);
        // Misaligned jump target, single-cycle flag
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h106,     32'h0000_0104, 32'h0000_0044, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b1, 1'b0);
        // Two conflict cycles freeze everything
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0108, 32'h0000_0104, 1'b1, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_010C, 32'h0000_0108, 1'b1, 1'b0);
        // Wrap at the top of the address space
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0108, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0);
        // Misaligned branch parked under stall
        vecs[21] = mk(1'b1, 1'b0, 1'b1, 32'h203,   1'b0, 32'h0,       32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0200, 32'h0000_0000, 1'b0, 1'b0);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0204, 32'h0000_0200, 1'b1, 1'b0);
        // Redirect wins over a simultaneous conflict
        vecs[24] = mk(1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h300,     32'h0000_0300, 32'h0000_0200, 1'b0, 1'b0);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0304, 32'h0000_0300, 1'b1, 1'b0);
        // Plain stall without redirect
        vecs[26] = mk(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0304, 32'h0000_0300, 1'b0, 1'b0);
        vecs[27] = mk(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       32'h0000_0308, 32'h0000_0304, 1'b1, 1'b0);

        // Reset
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b1;
        tick();
        tick();
        check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].conflict, vecs[i].br, vecs[i].br_tgt,
                  vecs[i].jmp, vecs[i].jmp_tgt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pc_if,
                      vecs[i].exp_valid, vecs[i].exp_mis);
        end

        // Park a redirect to 0x300 in HOLD, then reset over it.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        tick();
        check_all("hold_park", 32'h308, 32'h304, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b1;
        tick();
        check_all("hold_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;

        // Boot cycle ignores a redirect; pending 0x300 must not reappear.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        tick();
        check_all("reboot0", 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_all("reboot1", 32'h4, 32'h0, 1'b1, 1'b0);
        tick();
        check_all("reboot2", 32'h8, 32'h4, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
